// File: rtl/johnson_phase_sequencer.sv
// Johnson-counter burst sequencer: runs Run_len full rotations of a WIDTH-bit Johnson
// counter, pulses Wrap on every rotation and Done on normal completion, and exports a
// one-hot phase decode of the counter while busy.
// Optional build macro JOHNSON_ILLEGAL_RECOVER_EN: clears illegal counter codes to zero
// and pulses o_err; without it the legality check is absent and o_err is tied low.
module johnson_phase_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CYCLES_W = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [CYCLES_W-1:0] i_run_len,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_wrap,
  output logic [WIDTH-1:0]    o_count_out,
  output logic [2*WIDTH-1:0]  o_phase_out,
  output logic                o_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              r_state, w_state_d;
  logic [WIDTH-1:0]    r_count, w_count_d;
  logic [CYCLES_W-1:0] r_remaining, w_remaining_d;
  logic                r_done, w_done_d;
  logic                r_wrap, w_wrap_d;
  logic                r_err, w_err_d;

  logic [WIDTH-1:0]    w_count_step;
  logic [WIDTH-1:0]    w_last_code;
  logic                w_at_last;
  logic [2*WIDTH-1:0]  w_phase_raw;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
  logic                w_legal;
`endif

  assign w_count_step = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
  // Final code of a rotation: MSB set, all else clear; its successor is all-zero.
  assign w_last_code  = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_at_last    = (r_count == w_last_code);

  // Phase decode: walk the legal Johnson sequence and flag the matching index.
  always_comb begin
    logic [WIDTH-1:0] code;
    w_phase_raw = '0;
    code        = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (r_count == code) w_phase_raw[k] = 1'b1;
      code = {code[WIDTH-2:0], ~code[WIDTH-1]};
    end
  end

`ifdef JOHNSON_ILLEGAL_RECOVER_EN
  // A code is legal exactly when it matches one of the 2*WIDTH sequence points.
  assign w_legal = |w_phase_raw;
`endif

  // State register and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_remaining <= w_remaining_d;
      r_done      <= w_done_d;
      r_wrap      <= w_wrap_d;
      r_err       <= w_err_d;
    end
  end

  // Next-state logic: burst start, Johnson stepping, rotation accounting, abort.
  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_remaining_d = r_remaining;
    w_done_d      = 1'b0;
    w_wrap_d      = 1'b0;
    w_err_d       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_count_d = '0;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
        if (r_count != '0) w_err_d = 1'b1;
`endif
        // Stop beats Start; a zero-length request completes without ever running.
        if (i_start && !i_stop) begin
          if (i_run_len != '0) begin
            w_state_d     = StRun;
            w_remaining_d = i_run_len;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (i_stop) begin
          // Abort wins over completion on the same edge: no Done, no Wrap.
          w_state_d     = StIdle;
          w_count_d     = '0;
          w_remaining_d = '0;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
        end else if (!w_legal) begin
          // Restart the rotation at phase 0; rotations left are not charged.
          w_count_d = '0;
          w_err_d   = 1'b1;
`endif
        end else begin
          w_count_d = w_count_step;
          if (w_at_last) begin
            w_wrap_d      = 1'b1;
            w_remaining_d = r_remaining - 1'b1;
            if (r_remaining == CYCLES_W'(1)) begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_count_d     = '0;
        w_remaining_d = '0;
      end
    endcase
  end

  // Output drive: registered flags straight out, phase decode gated by Busy.
  always_comb begin
    o_busy      = (r_state == StRun);
    o_done      = r_done;
    o_wrap      = r_wrap;
    o_err       = r_err;
    o_count_out = r_count;
    o_phase_out = o_busy ? w_phase_raw : '0;
  end

endmodule
